// File: rtl/tnn_pkg.sv
// Shared types and helpers for the ternary activation store path.
package tnn_pkg;

    localparam int unsigned WORD_WIDTH     = 32;
    localparam int unsigned BYTES_PER_WORD = 4;

    typedef struct packed {
        logic [BYTES_PER_WORD-1:0] be;
        logic [WORD_WIDTH-1:0]     data;
    } word_entry_t;

    function automatic int unsigned chunks_per_word(input int unsigned chunk_width);
        return WORD_WIDTH / chunk_width;
    endfunction

    // Byte enables covering the first 'fill' chunks of a word.
    function automatic logic [BYTES_PER_WORD-1:0] partial_be(input int unsigned fill,
                                                             input int unsigned bytes_per_chunk);
        logic [BYTES_PER_WORD-1:0] be;
        be = '0;
        for (int unsigned b = 0; b < BYTES_PER_WORD; b++) begin
            be[b] = (b < fill * bytes_per_chunk);
        end
        return be;
    endfunction

endpackage

// File: rtl/tnn_word_fifo.sv
// Small synchronous FIFO with occupancy counter and wrap-around pointers.
module tnn_word_fifo #(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_incr(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (cnt_q == CntW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_incr(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_incr(rd_ptr_q);
            cnt_d = cnt_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (do_push && !clear_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/ternary_word_packer.sv
// Packs compressed ternary chunks little-endian into 32-bit words with flushable partial words.
module ternary_word_packer
    import tnn_pkg::*;
#(
    parameter int unsigned CHUNK_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH  = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic [CHUNK_WIDTH-1:0] chunk_i,
    input  logic                   chunk_valid_i,
    output logic                   chunk_ready_o,
    input  logic                   flush_i,
    output logic [WORD_WIDTH-1:0]  word_o,
    output logic [3:0]             word_be_o,
    output logic                   word_valid_o,
    input  logic                   word_ready_i,
    output logic                   idle_o
);

    localparam int unsigned N             = chunks_per_word(CHUNK_WIDTH);
    localparam int unsigned BytesPerChunk = CHUNK_WIDTH / 8;

    if (!(CHUNK_WIDTH == 8 || CHUNK_WIDTH == 16 || CHUNK_WIDTH == 32)) begin : g_bad_chunk_width
        $error("ternary_word_packer: CHUNK_WIDTH must be 8, 16 or 32");
    end
    if (FIFO_DEPTH < 1) begin : g_bad_fifo_depth
        $error("ternary_word_packer: FIFO_DEPTH must be at least 1");
    end

    logic [1:0]            fill_q, fill_d;
    logic [WORD_WIDTH-1:0] acc_q, acc_d, acc_ins;
    logic                  flush_pending_q, flush_pending_d;
    logic                  accept, fifo_full, fifo_empty, push, pop;
    word_entry_t           push_entry, head_entry;

    assign chunk_ready_o = !fifo_full && !flush_pending_q;
    assign accept        = chunk_valid_i && chunk_ready_o;
    assign word_valid_o  = !fifo_empty;
    assign pop           = word_valid_o && word_ready_i;
    assign idle_o        = (fill_q == '0) && fifo_empty && !flush_pending_q;
    // Gate the head so an empty FIFO always presents zeros.
    assign word_o        = word_valid_o ? head_entry.data : '0;
    assign word_be_o     = word_valid_o ? head_entry.be : '0;

    always_comb begin
        acc_ins = acc_q;
        acc_ins[CHUNK_WIDTH*fill_q +: CHUNK_WIDTH] = chunk_i;
    end

    always_comb begin
        fill_d          = fill_q;
        acc_d           = acc_q;
        flush_pending_d = flush_pending_q;
        push            = 1'b0;
        push_entry      = '0;
        if (clear_i) begin
            fill_d          = '0;
            acc_d           = '0;
            flush_pending_d = 1'b0;
        end else begin
            if (accept) begin
                if (fill_q == 2'(N - 1)) begin
                    push            = 1'b1;
                    push_entry.data = acc_ins;
                    push_entry.be   = 4'hF;
                    fill_d          = '0;
                    acc_d           = '0;
                end else begin
                    fill_d = fill_q + 2'd1;
                    acc_d  = acc_ins;
                end
            end else if (flush_pending_q && !fifo_full) begin
                // Chunks are blocked while pending, so this never races a full-word push.
                push            = (fill_q != '0);
                push_entry.data = acc_q;
                push_entry.be   = partial_be(32'(fill_q), BytesPerChunk);
                fill_d          = '0;
                acc_d           = '0;
                flush_pending_d = 1'b0;
            end
            if (flush_i) flush_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fill_q          <= '0;
            acc_q           <= '0;
            flush_pending_q <= 1'b0;
        end else begin
            fill_q          <= fill_d;
            acc_q           <= acc_d;
            flush_pending_q <= flush_pending_d;
        end
    end

    tnn_word_fifo #(
        .WIDTH ($bits(word_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule
